// File: rtl/home_automation_pkg.sv
// ============================================================================
// Module : home_automation_pkg
// Brief  : Shared opcodes, AC mode codes and controller FSM states.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package home_automation_pkg;

   localparam int CMD_NOP          = 0;
   localparam int CMD_SET_ECO      = 1;
   localparam int CMD_SET_AC_MODE  = 2;
   localparam int CMD_SET_SECURITY = 3;
   localparam int CMD_PERSON_SET   = 4;
   localparam int CMD_PERSON_INC   = 5;
   localparam int CMD_PERSON_DEC   = 6;
   localparam int CMD_RESERVED     = 7;

   localparam logic [1:0] AC_OFF  = 2'b00;
   localparam logic [1:0] AC_HEAT = 2'b01;
   localparam logic [1:0] AC_COOL = 2'b10;
   localparam logic [1:0] AC_AUTO = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_DEAD = 2'd2
   } ctrl_state_t;

endpackage

`default_nettype wire

// File: rtl/person_counter_sat.sv
// ============================================================================
// Module : person_counter_sat
// Brief  : Person counter with load and signed delta, saturating at 0 / max.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module person_counter_sat #(
   parameter int PCNT_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_load,
   input  logic [PCNT_W-1:0] i_load_val,
   input  logic signed [2:0] i_delta,
   output logic [PCNT_W-1:0] o_count
);

   localparam logic signed [PCNT_W+1:0] c_MAX = {2'b00, {PCNT_W{1'b1}}};

   logic [PCNT_W-1:0]        r_count;
   logic signed [PCNT_W+1:0] w_sum;

   // Two guard bits let the sum go below zero or past max before clamping.
   assign w_sum = $signed({2'b00, r_count}) + $signed({{(PCNT_W-1){i_delta[2]}}, i_delta});

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (w_sum < 0) begin
         r_count <= '0;
      end else if (w_sum > c_MAX) begin
         r_count <= '1;
      end else begin
         r_count <= w_sum[PCNT_W-1:0];
      end
   end

   assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/home_command_controller.sv
// ============================================================================
// Module : home_command_controller
// Brief  : Command decoder owning ECO/AC/security/person-count registers,
//          with AC OFF dead-time between two different active modes.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module home_command_controller
   import home_automation_pkg::*;
#(
   parameter int TYPE_W      = 3,
   parameter int DATA_W      = 8,
   parameter int PCNT_W      = 8,
   parameter int AC_DEADTIME = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              command_valid_i,
   output logic              command_ready_o,
   input  logic [TYPE_W-1:0] command_type_i,
   input  logic [DATA_W-1:0] command_data_i,
   input  logic              person_enter_i,
   input  logic              person_exit_i,
   output logic              eco_mode_valid_o,
   output logic [1:0]        ac_working_mode_o,
   output logic [PCNT_W-1:0] person_count_o,
   output logic              security_control_valid_o,
   output logic              command_error_o,
   output logic              busy_o
);

   localparam int c_CNT_W = $clog2(AC_DEADTIME + 1);

   ctrl_state_t         r_state;
   logic [TYPE_W-1:0]   r_type;
   logic [DATA_W-1:0]   r_data;
   logic [c_CNT_W-1:0]  r_dead_cnt;
   logic [1:0]          r_pending;
   logic                r_ready;
   logic                r_eco;
   logic [1:0]          r_ac;
   logic                r_sec;
   logic                r_err;
   logic                r_busy;

   logic                w_exec;
   logic                w_err;
   logic                w_load;
   logic [1:0]          w_new_mode;
   logic signed [2:0]   w_sns_delta;
   logic signed [2:0]   w_cmd_delta;
   logic signed [2:0]   w_delta;

   assign w_exec     = (r_state == ST_EXEC);
   assign w_new_mode = r_data[1:0];
   assign w_err      = w_exec && ((r_type >= TYPE_W'(CMD_RESERVED)) ||
                       ((r_type == TYPE_W'(CMD_SET_AC_MODE)) && (r_data[DATA_W-1:2] != '0)));
   assign w_load     = w_exec && (r_type == TYPE_W'(CMD_PERSON_SET));

   assign w_sns_delta = $signed({2'b00, person_enter_i}) - $signed({2'b00, person_exit_i});

   always_comb begin
      w_cmd_delta = 3'sd0;
      if (w_exec && (r_type == TYPE_W'(CMD_PERSON_INC))) begin
         w_cmd_delta = 3'sd1;
      end else if (w_exec && (r_type == TYPE_W'(CMD_PERSON_DEC))) begin
         w_cmd_delta = -3'sd1;
      end
   end

   assign w_delta = w_sns_delta + w_cmd_delta;

   person_counter_sat #(
      .PCNT_W (PCNT_W)
   ) u_person_counter (
      .clk        (clk_i),
      .rst        (rst_i),
      .i_load     (w_load),
      .i_load_val (PCNT_W'(r_data)),
      .i_delta    (w_delta),
      .o_count    (person_count_o)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state    <= ST_IDLE;
         r_type     <= '0;
         r_data     <= '0;
         r_dead_cnt <= '0;
         r_pending  <= AC_OFF;
         r_ready    <= 1'b0;
         r_eco      <= 1'b0;
         r_ac       <= AC_OFF;
         r_sec      <= 1'b0;
         r_err      <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_err <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_ready <= 1'b1;
               if (command_valid_i && r_ready) begin
                  r_type  <= command_type_i;
                  r_data  <= command_data_i;
                  r_ready <= 1'b0;
                  r_state <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               r_state <= ST_IDLE;
               r_ready <= 1'b1;
               if (w_err) begin
                  r_err <= 1'b1;
               end else if (r_type == TYPE_W'(CMD_SET_ECO)) begin
                  r_eco <= r_data[0];
               end else if (r_type == TYPE_W'(CMD_SET_SECURITY)) begin
                  r_sec <= r_data[0];
               end else if (r_type == TYPE_W'(CMD_SET_AC_MODE)) begin
                  // Active-to-different-active needs the compressor idle first.
                  if ((r_ac != AC_OFF) && (w_new_mode != AC_OFF) && (w_new_mode != r_ac)) begin
                     r_ac       <= AC_OFF;
                     r_pending  <= w_new_mode;
                     r_dead_cnt <= c_CNT_W'(AC_DEADTIME);
                     r_busy     <= 1'b1;
                     r_ready    <= 1'b0;
                     r_state    <= ST_DEAD;
                  end else begin
                     r_ac <= w_new_mode;
                  end
               end
            end
            ST_DEAD: begin
               if (r_dead_cnt <= c_CNT_W'(1)) begin
                  r_ac       <= r_pending;
                  r_dead_cnt <= '0;
                  r_busy     <= 1'b0;
                  r_ready    <= 1'b1;
                  r_state    <= ST_IDLE;
               end else begin
                  r_dead_cnt <= r_dead_cnt - c_CNT_W'(1);
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_ready <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign command_ready_o          = r_ready;
   assign eco_mode_valid_o         = r_eco;
   assign ac_working_mode_o        = r_ac;
   assign security_control_valid_o = r_sec;
   assign command_error_o          = r_err;
   assign busy_o                   = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_home_command_controller.sv
// ============================================================================
// Module : tb_home_command_controller
// Brief  : Scoreboard bench for home_command_controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_home_command_controller;
   import home_automation_pkg::*;

   localparam int TYPE_W      = 3;
   localparam int DATA_W      = 8;
   localparam int PCNT_W      = 8;
   localparam int AC_DEADTIME = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic              valid;
   logic              ready;
   logic [TYPE_W-1:0] ctype;
   logic [DATA_W-1:0] cdata;
   logic              enter;
   logic              leave;
   logic              eco;
   logic [1:0]        mode;
   logic [PCNT_W-1:0] count;
   logic              sec;
   logic              err;
   logic              busy;

   int                errors = 0;
   int                checks = 0;
   logic [14:0]       sb_q[$];
   logic [14:0]       exp_v;
   logic [14:0]       obs_v;

   home_command_controller #(
      .TYPE_W      (TYPE_W),
      .DATA_W      (DATA_W),
      .PCNT_W      (PCNT_W),
      .AC_DEADTIME (AC_DEADTIME)
   ) dut (
      .clk_i                    (clk),
      .rst_i                    (rst),
      .command_valid_i          (valid),
      .command_ready_o          (ready),
      .command_type_i           (ctype),
      .command_data_i           (cdata),
      .person_enter_i           (enter),
      .person_exit_i            (leave),
      .eco_mode_valid_o         (eco),
      .ac_working_mode_o        (mode),
      .person_count_o           (count),
      .security_control_valid_o (sec),
      .command_error_o          (err),
      .busy_o                   (busy)
   );

   always #5 clk = ~clk;

   // Packed layout: ready, eco, mode[1:0], sec, err, busy, count[7:0]
   function automatic logic [14:0] mk(input logic r, input logic e, input logic [1:0] m,
                                      input logic s, input logic er, input logic b,
                                      input logic [7:0] c);
      return {r, e, m, s, er, b, c};
   endfunction

   function automatic logic [14:0] snap();
      return {ready, eco, mode, sec, err, busy, count};
   endfunction

   // Called just after a negedge; returns at the negedge of the EXEC cycle.
   task automatic send_cmd(input logic [TYPE_W-1:0] t, input logic [DATA_W-1:0] d);
      int n = 0;
      valid = 1'b1;
      ctype = t;
      cdata = d;
      while (ready !== 1'b1 && n < 64) begin
         @(negedge clk);
         n++;
      end
      if (ready !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL send_cmd_timeout: ready=%b after %0d cycles, want 1", ready, n);
      end
      @(negedge clk);
      valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (snap() !== 15'h0) begin
         errors++;
         $display("FAIL reset_outputs: got %h want %h", snap(), 15'h0);
      end
      rst = 1'b0;
      sb_q.push_back(mk(1, 0, AC_OFF, 0, 0, 0, 0));
      @(negedge clk);
      exp_v = sb_q.pop_front();
      checks++;
      if (snap() !== exp_v) begin
         errors++;
         $display("FAIL reset_release_ready: got %h want %h", snap(), exp_v);
      end
      send_cmd(TYPE_W'(CMD_SET_ECO), 8'h01);
      sb_q.push_back(mk(0, 0, AC_OFF, 0, 0, 0, 0));
      sb_q.push_back(mk(1, 1, AC_OFF, 0, 0, 0, 0));
      exp_v = sb_q.pop_front();
      checks++;
      if (snap() !== exp_v) begin
         errors++;
         $display("FAIL eco_exec_cycle: got %h want %h", snap(), exp_v);
      end
      @(negedge clk);
      exp_v = sb_q.pop_front();
      checks++;
      if (snap() !== exp_v) begin
         errors++;
         $display("FAIL eco_applied: got %h want %h", snap(), exp_v);
      end
   endtask

   task automatic test_deadtime();
      send_cmd(TYPE_W'(CMD_SET_AC_MODE), 8'h01);
      sb_q.push_back(mk(1, 1, AC_HEAT, 0, 0, 0, 0));
      @(negedge clk);
      exp_v = sb_q.pop_front();
      checks++;
      if (snap() !== exp_v) begin
         errors++;
         $display("FAIL off_to_heat: got %h want %h", snap(), exp_v);
      end
      send_cmd(TYPE_W'(CMD_SET_AC_MODE), 8'h02);
      for (int i = 0; i < AC_DEADTIME; i++) sb_q.push_back(mk(0, 1, AC_OFF, 0, 0, 1, 0));
      sb_q.push_back(mk(1, 1, AC_COOL, 0, 0, 0, 0));
      for (int i = 0; i <= AC_DEADTIME; i++) begin
         @(negedge clk);
         exp_v = sb_q.pop_front();
         checks++;
         if (snap() !== exp_v) begin
            errors++;
            $display("FAIL heat_to_cool_cycle%0d: got %h want %h", i, snap(), exp_v);
         end
      end
   endtask

   task automatic test_saturation();
      int m;
      send_cmd(TYPE_W'(CMD_PERSON_SET), 8'd254);
      @(negedge clk);
      m = 254;
      for (int i = 0; i < 3; i++) begin
         enter = 1'b1;
         m = (m >= 255) ? 255 : m + 1;
         sb_q.push_back(mk(1, 1, AC_COOL, 0, 0, 0, m[7:0]));
         @(negedge clk);
         enter = 1'b0;
         exp_v = sb_q.pop_front();
         checks++;
         if (snap() !== exp_v) begin
            errors++;
            $display("FAIL sat_max_enter%0d: got %h want %h", i, snap(), exp_v);
         end
      end
      send_cmd(TYPE_W'(CMD_PERSON_SET), 8'd0);
      @(negedge clk);
      leave = 1'b1;
      sb_q.push_back(mk(1, 1, AC_COOL, 0, 0, 0, 8'd0));
      @(negedge clk);
      leave = 1'b0;
      exp_v = sb_q.pop_front();
      checks++;
      if (snap() !== exp_v) begin
         errors++;
         $display("FAIL sat_zero_exit: got %h want %h", snap(), exp_v);
      end
      send_cmd(TYPE_W'(CMD_PERSON_SET), 8'd5);
      @(negedge clk);
      enter = 1'b1;
      leave = 1'b1;
      sb_q.push_back(mk(1, 1, AC_COOL, 0, 0, 0, 8'd5));
      @(negedge clk);
      enter = 1'b0;
      leave = 1'b0;
      exp_v = sb_q.pop_front();
      checks++;
      if (snap() !== exp_v) begin
         errors++;
         $display("FAIL enter_exit_cancel: got %h want %h", snap(), exp_v);
      end
   endtask

   task automatic test_cmd_with_sensor();
      send_cmd(TYPE_W'(CMD_PERSON_SET), 8'd10);
      @(negedge clk);
      send_cmd(TYPE_W'(CMD_PERSON_INC), 8'd0);
      enter = 1'b1;
      sb_q.push_back(mk(1, 1, AC_COOL, 0, 0, 0, 8'd12));
      @(negedge clk);
      enter = 1'b0;
      exp_v = sb_q.pop_front();
      checks++;
      if (snap() !== exp_v) begin
         errors++;
         $display("FAIL inc_plus_enter: got %h want %h", snap(), exp_v);
      end
      send_cmd(TYPE_W'(CMD_PERSON_SET), 8'd40);
      leave = 1'b1;
      sb_q.push_back(mk(1, 1, AC_COOL, 0, 0, 0, 8'd40));
      @(negedge clk);
      leave = 1'b0;
      exp_v = sb_q.pop_front();
      checks++;
      if (snap() !== exp_v) begin
         errors++;
         $display("FAIL set_ignores_exit: got %h want %h", snap(), exp_v);
      end
   endtask

   task automatic test_errors();
      logic [TYPE_W-1:0] t;
      logic [DATA_W-1:0] d;
      for (int k = 0; k < 2; k++) begin
         t = (k == 0) ? TYPE_W'(CMD_RESERVED) : TYPE_W'(CMD_SET_AC_MODE);
         d = (k == 0) ? 8'h00 : 8'h05;
         send_cmd(t, d);
         sb_q.push_back(mk(0, 1, AC_COOL, 0, 0, 0, 8'd40));
         sb_q.push_back(mk(1, 1, AC_COOL, 0, 1, 0, 8'd40));
         sb_q.push_back(mk(1, 1, AC_COOL, 0, 0, 0, 8'd40));
         for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            exp_v = sb_q.pop_front();
            checks++;
            if (snap() !== exp_v) begin
               errors++;
               $display("FAIL error_cmd%0d_cycle%0d: got %h want %h", k, i, snap(), exp_v);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      valid = 1'b1;
      ctype = TYPE_W'(CMD_SET_SECURITY);
      cdata = 8'h01;
      sb_q.push_back(mk(0, 1, AC_COOL, 0, 0, 0, 8'd40));
      sb_q.push_back(mk(1, 1, AC_COOL, 1, 0, 0, 8'd40));
      sb_q.push_back(mk(0, 1, AC_COOL, 1, 0, 0, 8'd40));
      sb_q.push_back(mk(1, 0, AC_COOL, 1, 0, 0, 8'd40));
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         obs_v = snap();
         if (i == 0) begin
            ctype = TYPE_W'(CMD_SET_ECO);
            cdata = 8'h00;
         end
         if (i == 2) valid = 1'b0;
         exp_v = sb_q.pop_front();
         checks++;
         if (obs_v !== exp_v) begin
            errors++;
            $display("FAIL back_to_back_cycle%0d: got %h want %h", i, obs_v, exp_v);
         end
      end
   endtask

   task automatic test_reset_in_deadtime();
      send_cmd(TYPE_W'(CMD_SET_AC_MODE), 8'h01);
      repeat (5) @(negedge clk);
      checks++;
      if (snap() !== mk(0, 0, AC_OFF, 1, 0, 1, 8'd40)) begin
         errors++;
         $display("FAIL dead_cycle5: got %h want %h", snap(), mk(0, 0, AC_OFF, 1, 0, 1, 8'd40));
      end
      rst = 1'b1;
      sb_q.push_back(15'h0);
      sb_q.push_back(mk(1, 0, AC_OFF, 0, 0, 0, 0));
      @(negedge clk);
      rst = 1'b0;
      exp_v = sb_q.pop_front();
      checks++;
      if (snap() !== exp_v) begin
         errors++;
         $display("FAIL reset_mid_dead: got %h want %h", snap(), exp_v);
      end
      @(negedge clk);
      exp_v = sb_q.pop_front();
      checks++;
      if (snap() !== exp_v) begin
         errors++;
         $display("FAIL reset_mid_dead_release: got %h want %h", snap(), exp_v);
      end
      send_cmd(TYPE_W'(CMD_SET_AC_MODE), 8'h02);
      sb_q.push_back(mk(1, 0, AC_COOL, 0, 0, 0, 0));
      sb_q.push_back(mk(1, 0, AC_COOL, 0, 0, 0, 0));
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         exp_v = sb_q.pop_front();
         checks++;
         if (snap() !== exp_v) begin
            errors++;
            $display("FAIL cool_after_reset%0d: got %h want %h", i, snap(), exp_v);
         end
      end
   endtask

   initial begin
      rst   = 1'b1;
      valid = 1'b0;
      ctype = '0;
      cdata = '0;
      enter = 1'b0;
      leave = 1'b0;
      test_reset();
      test_deadtime();
      test_saturation();
      test_cmd_with_sensor();
      test_errors();
      test_back_to_back();
      test_reset_in_deadtime();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
